// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives a request and operands; the slave returns status and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A single borrow flop ripples between bit slices; results update only on the done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic             d_bit;
    logic             borrow_nxt;
    logic [WIDTH-1:0] r_nxt;
    logic             last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (last_bit)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == IDLE);
        bus.busy  = (state_q != IDLE);
        bus.done  = done_q;
        bus.diff  = diff_q;
        bus.bout  = bout_q;
        bus.ovf   = ovf_q;
        bus.zero  = zero_q;
    end

    // One full-subtractor slice on the current LSBs; its sum bit enters r_sh from the top.
    always_comb begin
        d_bit      = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
        borrow_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
        r_nxt      = {d_bit, r_sh_q[WIDTH-1:1]};
        last_bit   = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    r_sh_d   = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                r_sh_d   = r_nxt;
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + 1'b1;
                // Signed overflow: operand signs differ and the result sign disagrees with a.
                if (last_bit) begin
                    diff_d = r_nxt;
                    bout_d = borrow_nxt;
                    zero_d = (r_nxt == '0);
                    ovf_d  = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed test of the 8-bit serial subtractor: reset, arithmetic cases, back-to-back
// operation, ignored mid-run start and asynchronous abort.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {ready, busy, done, diff, bout, ovf, zero}; reset value is 14'h2000.
    function automatic logic [31:0] status_vec();
        return 32'({bus.ready, bus.busy, bus.done, bus.diff, bus.bout, bus.ovf, bus.zero});
    endfunction

    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
    endtask

    // Waits for done after an accept edge; returns at the negedge where done is seen.
    task automatic check_output(input string tag, input bit inject_mid,
                                input logic [WIDTH-1:0] exp_diff, input logic exp_bout,
                                input logic exp_ovf, input logic exp_zero);
        int k;
        int busy_cycles;
        bit seen;
        k = 0;
        busy_cycles = 0;
        seen = 1'b0;
        while (!seen && k < 4 * WIDTH) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = ~bus.a;
                bus.b     = ~bus.b;
            end
            if (inject_mid && k == 4) apply_stimulus(8'hAA, 8'h11);
            if (inject_mid && k == 5) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, k - 1, WIDTH);
        check({tag, "_busy_cycles"}, busy_cycles, WIDTH);
        check({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        check({tag, "_flags"}, 32'({bus.bout, bus.ovf, bus.zero}),
              32'({exp_bout, exp_ovf, exp_zero}));
        check({tag, "_ready_in_done"}, 32'({bus.ready, bus.busy}), 32'b10);
    endtask

    initial begin
        int saw_done;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        $display("[TB] test 1: reset and idle");
        repeat (3) @(negedge clk);
        check("in_reset", status_vec(), 32'h2000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_after_reset", status_vec(), 32'h2000);
        end

        $display("[TB] test 2: 0x35 - 0x12");
        apply_stimulus(8'h35, 8'h12);
        check_output("t2", 1'b0, 8'h23, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_done_one_cycle", 32'(bus.done), 0);
        repeat (5) @(negedge clk);
        check("t2_hold", status_vec(), 32'({3'b100, 8'h23, 3'b000}));

        $display("[TB] test 3: 0x12 - 0x35");
        apply_stimulus(8'h12, 8'h35);
        check_output("t3", 1'b0, 8'hDD, 1'b1, 1'b0, 1'b0);

        $display("[TB] test 4: signed overflow cases");
        @(negedge clk);
        apply_stimulus(8'h80, 8'h01);
        check_output("t4a", 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        apply_stimulus(8'h7F, 8'hFF);
        check_output("t4b", 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

        $display("[TB] test 5: back-to-back with ignored mid-run start");
        @(negedge clk);
        apply_stimulus(8'h5A, 8'h5A);
        check_output("t5a", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'h01, 8'h02);
        check_output("t5b", 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);

        $display("[TB] test 6: asynchronous abort");
        @(negedge clk);
        apply_stimulus(8'hF0, 8'h0F);
        saw_done = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (bus.done) saw_done++;
        end
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", status_vec(), 32'h2000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_held_in_reset", status_vec(), 32'h2000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) saw_done++;
        end
        check("t6_no_done_for_abort", saw_done, 0);
        check("t6_idle_after_abort", status_vec(), 32'h2000);
        apply_stimulus(8'hF0, 8'h0F);
        check_output("t6", 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
